// File: rtl/argmax_scan.sv
// Sequential argmax over a signed result memory; reports the low bits of the winning index.
// Define ARGMAX_SYNC_READ_EN for a memory with one-cycle registered read latency.
module argmax_scan #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] size,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  max_index,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         size_q, size_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W-1:0]         best_idx_q, best_idx_d;
  logic signed [DATA_W-1:0]  best_val_q, best_val_d;
  logic [IDX_W-1:0]          max_q, max_d;
  logic                      consume;
  logic                      take;

`ifdef ARGMAX_SYNC_READ_EN
  // Set once the first address has been presented, i.e. read data is now valid.
  logic primed_q, primed_d;
`endif

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    max_d      = max_q;
    consume    = 1'b0;
    take       = 1'b0;
`ifdef ARGMAX_SYNC_READ_EN
    primed_d   = primed_q;
`endif

    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (start) begin
          size_d  = size;
          idx_d   = '0;
          state_d = StScan;
`ifdef ARGMAX_SYNC_READ_EN
          primed_d = 1'b0;
`endif
        end
      end

      StScan: begin
        if (size_q == '0) begin
          max_d   = '0;
          state_d = StFinish;
        end else begin
`ifdef ARGMAX_SYNC_READ_EN
          if (!primed_q) begin
            primed_d = 1'b1;
            addr_d   = addr_q + ADDR_W'(1);
          end else begin
            consume = 1'b1;
          end
`else
          consume = 1'b1;
`endif
        end

        if (consume) begin
          // First element always seeds the best; later ones must be strictly greater.
          take = (idx_q == '0) || ($signed(data) > best_val_q);
          if (take) begin
            best_val_d = $signed(data);
            best_idx_d = idx_q;
          end
          if (idx_q == size_q - ADDR_W'(1)) begin
            max_d   = best_idx_d[IDX_W-1:0];
            addr_d  = '0;
            state_d = StFinish;
          end else begin
            idx_d  = idx_q + ADDR_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      StFinish: begin
        addr_d  = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      size_q     <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      max_q      <= '0;
`ifdef ARGMAX_SYNC_READ_EN
      primed_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      max_q      <= max_d;
`ifdef ARGMAX_SYNC_READ_EN
      primed_q   <= primed_d;
`endif
    end
  end

  assign addr      = addr_q;
  assign max_index = max_q;
  assign done      = (state_q == StFinish);

endmodule

// File: tb/tb_argmax_scan.sv
// Directed and randomized checks of argmax_scan against an array-based argmax model.
module tb_argmax_scan;

`ifdef ARGMAX_SYNC_READ_EN
  localparam int ReadLat = 1;
`else
  localparam int ReadLat = 0;
`endif

  logic        clk;
  logic        resetn;
  logic        start;
  logic [15:0] size;
  logic [15:0] addr;
  logic [31:0] data;
  logic [3:0]  max_index;
  logic        done;

  logic signed [31:0] mem [64];
  int tests;
  int fails;
  logic [3:0] cur_max;

  argmax_scan #(.DATA_W(32), .ADDR_W(16), .IDX_W(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .data      (data),
    .max_index (max_index),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ARGMAX_SYNC_READ_EN
  always @(posedge clk) data <= mem[addr[5:0]];
`else
  assign data = mem[addr[5:0]];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest index holding the largest signed value among the first n words.
  function automatic logic [3:0] ref_argmax(input int n);
    int bi;
    bi = 0;
    for (int i = 1; i < n; i++)
      if (mem[i] > mem[bi]) bi = i;
    return bi[3:0];
  endfunction

  task automatic fill(input logic signed [31:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic run_scan(input string tag, input int n, input bit mid_start);
    logic [3:0] exp;
    int lat;
    exp = (n == 0) ? 4'd0 : ref_argmax(n);
    lat = (n == 0) ? 1 : n + ReadLat;
    @(negedge clk);
    size  = 16'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk);
      #1 start = 1'b0;
      chk({tag, " done"}, {31'd0, done}, {31'd0, k == lat});
      if (k < lat) chk({tag, " held"}, {28'd0, max_index}, {28'd0, cur_max});
      if (k == lat) begin
        chk({tag, " max_index"}, {28'd0, max_index}, {28'd0, exp});
        cur_max = exp;
      end
      if (mid_start && k == 2) start = 1'b1;
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    cur_max = 4'd0;
    resetn  = 1'b0;
    start   = 1'b0;
    size    = '0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset addr", {16'd0, addr}, 32'd0);
    chk("reset max", {28'd0, max_index}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 64; i++) mem[i] = i;
    run_scan("ramp", 10, 1'b0);

    fill(-100);
    mem[3] = -5;
    run_scan("neg", 10, 1'b0);

    fill(0);
    mem[2] = 1000;
    mem[7] = 1000;
    run_scan("tie", 10, 1'b0);

    fill(0);
    mem[0] = -7;
    run_scan("size1", 1, 1'b0);
    run_scan("size0", 0, 1'b0);

    fill(0);
    mem[5] = 50;
    run_scan("prior5", 10, 1'b0);
    mem[8] = 80;
    run_scan("then8", 10, 1'b0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      run_scan("rand", $urandom_range(40, 1), 1'b0);
    end

    for (int i = 0; i < 64; i++) mem[i] = $urandom_range(200, 0) - 100;
    run_scan("mid_start", 12, 1'b1);

    // Reset sampled at E4 of a size-10 scan.
    for (int i = 0; i < 64; i++) mem[i] = i;
    @(negedge clk);
    size  = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    chk("abort addr", {16'd0, addr}, 32'd0);
    chk("abort max", {28'd0, max_index}, 32'd0);
    cur_max = 4'd0;
    for (int k = 0; k < 14; k++) begin
      chk("abort done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
    end
    run_scan("post_reset", 7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
